serial_tx_piso: RTL and testbench
=================================

Name: serial_tx_piso

Overview:
- Parallel-in, serial-out asynchronous-frame transmitter.
- Accepts one DATA_W-bit word per valid/ready handshake and shifts it onto a single line, LSB first.
- Frame format: start bit (0), data bits, optional parity bit, stop bit (1).
- Transmit end of the course serial link; feeds the matching serial receiver and scope/VCD-driven labs.

Parameters:
- DATA_W, 8, data bits per frame (legal range 1..16).
- CLKS_PER_BIT, 4, clock cycles each bit is held on tx_serial (legal range ≥1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- tx_data  input  DATA_W  word to send; sampled only at handshake
- tx_valid  input  1  word available
- tx_ready  output  1  block can accept a word; high only in IDLE
- tx_serial  output  1  serial line; idles high
- tx_busy  output  1  high while a frame is in flight (any state except IDLE)
- tx_done  output  1  one-cycle pulse in the last cycle of the stop bit

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE, tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Shift register, bit counter and baud counter all 0.
- Handshake:
  - Transfer occurs on a rising edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register at that edge.
  - Later changes to tx_data have no effect on the frame.
  - tx_valid while busy is ignored; it is not queued.
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: tx_serial=1. On transfer → START, baud counter=0.
  - START: tx_serial=0 for CLKS_PER_BIT cycles → DATA, bit index=0.
  - DATA: tx_serial=shift[0]. Every CLKS_PER_BIT cycles the register shifts right and the index increments. After DATA_W bits → PARITY if enabled, else → STOP.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles. tx_done=1 in the final cycle, then → IDLE.
- Timing:
  - tx_serial falls in the cycle immediately after the accepting edge.
  - Frame length is (DATA_W+2)*CLKS_PER_BIT cycles, or (DATA_W+3)*CLKS_PER_BIT with parity.
  - With tx_valid held high, back-to-back frames are separated by exactly one idle-high cycle (the IDLE cycle in which tx_ready=1).
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. A bit transition occurs on the wrap. CLKS_PER_BIT=1 gives one bit per cycle with no counter stall.
- Bit counter width is $clog2(DATA_W+1). Wrap is compared against DATA_W-1.
- Reset mid-frame:
  - Frame aborted; tx_serial=1 in the cycle after the reset edge.
  - No tx_done is generated.
  - rst has priority over a simultaneous handshake.
- tx_ready and tx_busy are decoded from state; they are never both high.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA.
  - tx_serial carries even parity, the XOR of all DATA_W bits latched at handshake, held for CLKS_PER_BIT cycles.
  - Frame grows by CLKS_PER_BIT cycles.
- Undefined:
  - No PARITY state, no parity register.
  - DATA goes directly to STOP.

Decomposition:
- Package serial_pkg:
  - state typedef/localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3-bit encoding).
  - LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module baud_tick:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, rst, en.
  - Output tick, a one-cycle pulse on counter wrap.
  - Counter cleared when en=0.
- FSM and shift register stay in serial_tx_piso.

Test Plan:
- Reset check: rst=1 for 2 cycles → tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0; hold with tx_valid=0 for 10 cycles → outputs unchanged.
- Single frame, DATA_W=8, CLKS_PER_BIT=4, tx_data=8'hA5 →
  - tx_serial: 0 ×4, then 1,0,1,0,0,1,0,1 (each ×4), then 1 ×4.
  - tx_done pulses once at cycle 40 after acceptance; tx_ready returns next cycle.
- Back-to-back: tx_valid held high with 8'h00 then 8'hFF →
  - two frames separated by exactly one idle-high cycle;
  - second frame data bits all 1;
  - exactly two tx_done pulses.
- Busy-ignore and data-hold: accept 8'h3C, then toggle tx_valid and change tx_data to 8'hC3 mid-frame → transmitted bits still 0,0,1,1,1,1,0,0; no extra frame.
- Reset mid-frame: assert rst during DATA bit 3 of 8'h55 →
  - tx_serial=1 on the next cycle; no tx_done;
  - next 8'h01 frame transmits cleanly.
- Parity (SERIAL_TX_PARITY_EN defined), CLKS_PER_BIT=1:
  - 8'h07 → parity bit 1, frame 11 cycles;
  - 8'h03 → parity bit 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial transmit path.
// SERIAL_TX_PARITY_EN selects the even-parity frame variant.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_piso_baud_tick.sv
// Baud divider: one-cycle tick on the last cycle of every bit period.
// Held at zero while disabled so each frame starts on a fresh period.
module baud_tick
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out frame transmitter, LSB first, start/stop framed.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit after the data.
module serial_tx_piso
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [IDX_W-1:0]  idx_q;
    logic              serial_q;
    logic              tick;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q;
`endif

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .en  (state_q != IDLE),
        .tick(tick)
    );

    assign shift_d = shift_q >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            serial_q <= LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    serial_q <= LINE_IDLE;
                    if (tx_valid) begin
                        shift_q  <= tx_data;
                        serial_q <= START_BIT;
                        state_q  <= START;
`ifdef SERIAL_TX_PARITY_EN
                        parity_q <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        serial_q <= shift_q[0];
                        idx_q    <= '0;
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= shift_d;
                        if (idx_q == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                            serial_q <= parity_q;
                            state_q  <= PARITY;
`else
                            serial_q <= STOP_BIT;
                            state_q  <= STOP;
`endif
                        end else begin
                            idx_q    <= idx_q + IDX_W'(1);
                            serial_q <= shift_d[0];
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        serial_q <= STOP_BIT;
                        state_q  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        serial_q <= LINE_IDLE;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    serial_q <= LINE_IDLE;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign tx_serial = serial_q;
    assign tx_ready  = (state_q == IDLE);
    assign tx_busy   = (state_q != IDLE);
    assign tx_done   = (state_q == STOP) && tick;

endmodule

// File: tb/tb_serial_tx_piso.sv
// Randomized frame checks against a bit-position model of the serial frame.
// Defining SERIAL_TX_PARITY_EN switches to one clock per bit with parity.
module tb_serial_tx_piso;

    localparam int DW = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int CPB = 1;
    localparam int PB  = 1;
`else
    localparam int CPB = 4;
    localparam int PB  = 0;
`endif
    localparam int FL = (DW + 2 + PB) * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_busy;
    logic          tx_done;

    int n_chk = 0;
    int n_bad = 0;

    serial_tx_piso #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_serial(tx_serial),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line level of frame slot j: start, data LSB first, parity, stop.
    function automatic logic exp_bit(input logic [DW-1:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= DW) return d[j-1];
        if (PB == 1 && j == DW + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        check(tag, {28'd0, tx_serial, tx_done, tx_busy, tx_ready}, 32'b1001);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tx_valid = 1'b0;
            idle_chk("idle");
            step();
        end
    endtask

    // mode 0: drop valid after accept, 1: hold valid, 2: scramble inputs.
    task automatic run_frame(input logic [DW-1:0] d, input int mode,
                             input int abort_at);
        logic exp_s;
        idle_chk("pre");
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        for (int k = 1; k <= FL; k++) begin
            if (k == abort_at) begin
                rst      = 1'b1;
                tx_valid = 1'b0;
                step();
                rst = 1'b0;
                idle_chk("abort");
                return;
            end
            exp_s = exp_bit(d, (k - 1) / CPB);
            check($sformatf("d%02h k%0d", d, k),
                  {28'd0, tx_serial, tx_done, tx_busy, tx_ready},
                  {28'd0, exp_s, (k == FL), 1'b1, 1'b0});
            case (mode)
                1: tx_valid = 1'b1;
                2: begin
                    tx_valid = 1'($urandom);
                    tx_data  = DW'($urandom);
                end
                default: tx_valid = 1'b0;
            endcase
            step();
        end
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        step();
        step();
        idle_chk("reset");
        rst = 1'b0;
        idle_cycles(10);

        run_frame(8'hA5, 0, 0);
        idle_cycles(2);

        run_frame(8'h00, 1, 0);
        run_frame(8'hFF, 0, 0);
        idle_cycles(3);

        run_frame(8'h3C, 2, 0);
        idle_cycles(5);

        run_frame(8'h55, 0, CPB * 4 + 1);
        idle_cycles(3);
        run_frame(8'h01, 0, 0);
        idle_cycles(1);

        tx_data  = 8'h9A;
        tx_valid = 1'b1;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        tx_valid = 1'b0;
        idle_chk("rst_prio");
        idle_cycles(2);

        run_frame(8'h07, 0, 0);
        idle_cycles(1);
        run_frame(8'h03, 0, 0);

        repeat (20) begin
            idle_cycles($urandom_range(0, 3));
            run_frame(DW'($urandom), $urandom_range(0, 2), 0);
        end
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
